// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Multicycle instruction fetch and sequencing block. Owns the program counter
// and the instruction register, runs the req/ack handshake toward instruction
// memory, exposes the decoded instruction fields to the control decoder, and
// computes the next PC from the decoder's branch/bequal outputs and the ALU
// zero flag.
//
// Each instruction alternates between two states:
//   FETCH : request the word at pc and wait for imem_ack (any latency,
//           including an ack in the same cycle as the request).
//   EXEC  : the IR is presented to the datapath. The instruction retires
//           on the first cycle with stall=0.
//
// Parameters:
//   RESET_PC    PC value loaded on reset (must be word-aligned)
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   imem_req    out  fetch request (FETCH state, gated off during reset)
//   imem_addr   out  fetch address, always equal to pc
//   imem_ack    in   imem_rdata is valid this cycle (used only in FETCH)
//   imem_rdata  in   instruction word
//   stall       in   datapath not ready to retire the current instruction
//   branch      in   current instruction is a conditional branch
//   bequal      in   1 = BEQ, 0 = BNE
//   zero        in   ALU zero flag for the current instruction
//   instr_valid out  IR holds the instruction executing this cycle
//   opcode      out  IR[31:26]
//   rs          out  IR[25:21]
//   rt          out  IR[20:16]
//   rd          out  IR[15:11]
//   func        out  IR[5:0]
//   imm         out  IR[15:0]
//   pc          out  address of the instruction in IR / being fetched
//   retired     out  count of retired instructions (wraps at 2^32)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic        bequal,
  input  logic        zero,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  func,
  output logic [15:0] imm,
  output logic [31:0] pc,
  output logic [31:0] retired
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] ir_reg;
  logic [31:0] ir_next;
  logic [31:0] retired_reg;
  logic [31:0] retired_next;

  // Raw state decodes, before reset gating.
  logic        fetch_active;
  logic        exec_active;

  // ---------------------------------------------------------------------------
  // Next-PC arithmetic. All sums are plain 32-bit adds, so wrap-around past
  // 32'hFFFF_FFFC is silent.
  // ---------------------------------------------------------------------------
  logic        branch_taken;
  logic [31:0] pc_plus4;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] next_pc;

  // BEQ takes the branch on zero, BNE on non-zero.
  assign branch_taken  = branch & (bequal ? zero : ~zero);
  assign pc_plus4      = pc_reg + 32'd4;
  // Word offset: 16-bit immediate sign-extended to 30 bits, then scaled by 4.
  assign branch_offset = {{14{ir_reg[15]}}, ir_reg[15:0], 2'b00};
  assign branch_target = pc_plus4 + branch_offset;
  assign next_pc       = branch_taken ? branch_target : pc_plus4;

  // ---------------------------------------------------------------------------
  // State register. Reset wins over everything, abandoning any in-flight
  // fetch or stalled instruction.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= FETCH;
      pc_reg      <= RESET_PC;
      ir_reg      <= 32'd0;
      retired_reg <= 32'd0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      retired_reg <= retired_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and state-decoded outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    retired_next = retired_reg;
    fetch_active = 1'b0;
    exec_active  = 1'b0;

    case (state_reg)
      FETCH: begin
        fetch_active = 1'b1;
        // pc is untouched here, so the request address stays stable until ack.
        if (imem_ack) begin
          ir_next    = imem_rdata;
          state_next = EXEC;
        end
      end

      EXEC: begin
        exec_active = 1'b1;
        // Acks arriving here are ignored; the IR only loads in FETCH, which
        // keeps the decoded fields stable across the whole EXEC period.
        if (!stall) begin
          retired_next = retired_reg + 32'd1;
          pc_next      = next_pc;
          state_next   = FETCH;
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // The request and valid strobes come straight from the state register, but
  // are forced low in the reset cycle itself, when the register may still
  // hold a pre-reset state.
  assign imem_req    = fetch_active & ~reset;
  assign instr_valid = exec_active & ~reset;
  assign imem_addr   = pc_reg;

  // Instruction field decode, straight from the IR.
  assign opcode  = ir_reg[31:26];
  assign rs      = ir_reg[25:21];
  assign rt      = ir_reg[20:16];
  assign rd      = ir_reg[15:11];
  assign func    = ir_reg[5:0];
  assign imm     = ir_reg[15:0];

  assign pc      = pc_reg;
  assign retired = retired_reg;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multicycle instruction fetch and sequencing block. It produces the instruction fields (opcode, func, rs, rt, rd, immediate) consumed by the control decoder. In return, it takes the decoder's branch/bequal outputs and the ALU zero flag and computes the next PC. It sits between the instruction memory and the decode/execute datapath, owns the PC and the instruction register, and handles a req/ack memory handshake with variable latency.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned
- clock  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address; equals pc
- imem_ack  input  1  memory has valid imem_rdata this cycle
- imem_rdata  input  32  instruction word
- stall  input  1  datapath not ready to retire current instruction
- branch  input  1  branch instruction (from control decoder)
- bequal  input  1  1 = BEQ, 0 = BNE (from control decoder)
- zero  input  1  ALU zero flag for current instruction
- instr_valid  output  1  IR holds an instruction being executed this cycle
- opcode  output  6  IR[31:26]
- rs  output  5  IR[25:21]
- rt  output  5  IR[20:16]
- rd  output  5  IR[15:11]
- func  output  6  IR[5:0]
- imm  output  16  IR[15:0]
- pc  output  32  address of the instruction in IR / being fetched
- retired  output  32  count of retired instructions

## Operation
- Two-state FSM: FETCH, EXEC. After reset the FSM is in FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc; both stable until ack.
  - On imem_ack: IR<=imem_rdata; next state EXEC.
  - Without ack: remain in FETCH.
- EXEC:
  - instr_valid=1, imem_req=0; opcode/func/fields decode combinationally from IR.
  - If stall=1: remain in EXEC; pc, IR and retired hold.
  - If stall=0, the instruction retires:
    - retired<=retired+1.
    - pc<=next_pc.
    - Next state FETCH.
- next_pc:
  - taken = branch & (bequal ? zero : ~zero).
  - pc_plus4 = pc+4.
  - target = pc_plus4 + {sext(imm),2'b00}, where sext(imm) is 30 bits.
  - next_pc = taken ? target : pc_plus4.
  - All arithmetic is 32-bit modulo 2^32. Wrap-around is silent: 32'hFFFF_FFFC+4 = 0.
- branch, bequal and zero are sampled only in EXEC with stall=0. They are ignored otherwise.
- imem_ack outside FETCH is ignored; IR is not written.
- retired wraps from 32'hFFFF_FFFF to 0.
- Reset values:
  - FSM=FETCH, pc=RESET_PC, IR=0 (so opcode=0, func=0, rs=rt=rd=0, imm=0).
  - instr_valid=0, retired=0.
  - imem_req=0 during the reset cycle itself; it is gated by reset.
- Reset has priority over all other inputs, including mid-fetch and mid-stall. The in-flight fetch is abandoned. The memory is reset by the same reset, so no stale ack follows.

## Timing
- imem_req, imem_addr and instr_valid are decoded combinationally from FSM state. All other state is registered on the rising edge of clock.
- Minimum cost is 2 cycles per instruction: ack in the first FETCH cycle, no stall.
- Per instruction: 1 + memory wait cycles + 1 + stall cycles.
- Same-cycle ack is legal: req rises on cycle N, ack arrives on cycle N, and instr_valid=1 on N+1.
- pc changes only on the edge ending an EXEC cycle with stall=0, or on reset.
- The new pc appears on imem_addr in the following FETCH cycle.
- Once in EXEC, IR is stable until the next ack, so the decoder outputs are stable for the entire EXEC (including stalls).

## Test plan
- Reset sequencing:
  - Stimulus: RESET_PC=32'h0040_0000; hold reset 2 cycles, then release.
  - Required response: instr_valid=0 and imem_req=0 during reset; imem_req=1 and imem_addr=32'h0040_0000 on the first cycle after release.
- Sequential fetch:
  - Stimulus: ack same cycle as req; words 32'h0000_0020, 32'h8C08_0004; branch=0.
  - Required response: pc advances by 4 every 2 cycles; opcode=0/func=32 then opcode=35; retired=2.
- BEQ taken and not taken:
  - Stimulus: pc=32'h100, imm=16'hFFFF, branch=1, bequal=1.
  - Required response: zero=1 gives pc=32'h100; zero=0 gives pc=32'h104.
- BNE with positive offset:
  - Stimulus: pc=32'h200, imm=3, bequal=0, zero=0.
  - Required response: pc=32'h210. Repeating with zero=1 gives 32'h204.
- Wait states and stall:
  - Stimulus: ack delayed 3 cycles; then stall=1 for 4 cycles in EXEC.
  - Required response: imem_addr is stable during the wait; IR, opcode and pc hold during the stall; retired increments exactly once.
- Corner cases:
  - Reset mid-stall: FSM returns to FETCH at RESET_PC and retired=0.
  - PC wrap: pc=32'hFFFF_FFFC with no branch gives pc=0.
